// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and default geometry for the array access arbiter
package arb_pkg;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} arb_state_t;

   localparam int DEF_DW    = 8;
   localparam int DEF_DEPTH = 128;
   localparam int DEF_AW    = $clog2(DEF_DEPTH);

endpackage

// File: rtl/reg_array.sv
// rtl/reg_array.sv - single-port storage array with synchronous write and registered read
module reg_array #(
   parameter int DW    = 8,
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic          clk,
   input  logic          wen,
   input  logic          ren,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   reg [DW-1:0] mem [DEPTH-1:0];

   // Contents are deliberately left unreset; only the owner's FSM decides what is valid.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[addr] <= wdata;
      end
      if (ren) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/array_access_arbiter.sv
// rtl/array_access_arbiter.sv - round-robin arbiter owning one shared single-port register array
module array_access_arbiter
   import arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      rdata,
   output logic               busy,
   output logic [2:0]         gnt_id
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t    state, state_nxt;
   logic [IW-1:0] rr_ptr, cmd_id, pick, nxt_ptr;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr, mem_addr;
   logic [DW-1:0] cmd_wdata, mem_rdata;
   logic          mem_wen, mem_ren;

   // First requester at or after ptr, wrapping modulo NREQ.
   function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] ptr);
      logic [IW-1:0] sel;
      logic          found;
      int            idx;
      sel   = ptr;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (!found && r[idx]) begin
            sel   = IW'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign pick     = rr_pick(req, rr_ptr);
   assign nxt_ptr  = (int'(cmd_id) == NREQ - 1) ? '0 : cmd_id + 1'b1;
   assign mem_addr = AW'(int'(cmd_addr) % DEPTH);
   assign gnt_id   = 3'(cmd_id);

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Write enable is gated by rstb so a reset landing on the GRANT edge cannot corrupt the array.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      mem_wen   = 1'b0;
      mem_ren   = 1'b0;
      case (state)
         S_IDLE: begin
            if (|req) begin
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            busy      = 1'b1;
            mem_wen   = cmd_we & rstb;
            mem_ren   = ~cmd_we;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         ack       <= '0;
         rdata     <= '0;
         rr_ptr    <= '0;
         cmd_id    <= '0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else begin
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  cmd_id    <= pick;
                  cmd_we    <= we[pick];
                  cmd_addr  <= addr[int'(pick)*AW +: AW];
                  cmd_wdata <= wdata[int'(pick)*DW +: DW];
               end
            end
            S_DONE: begin
               ack    <= {{(NREQ-1){1'b0}}, 1'b1} << cmd_id;
               rr_ptr <= nxt_ptr;
               if (!cmd_we) begin
                  rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   reg_array #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_array (
      .clk   (clk),
      .wen   (mem_wen),
      .ren   (mem_ren),
      .addr  (mem_addr),
      .wdata (cmd_wdata),
      .rdata (mem_rdata)
   );

endmodule
